// File: rtl/n_way_mux_pkg.sv
// Shared definitions for the n_way_mux_arb channel selector.
//   MODE_FIXED / MODE_RR : values of the mode input
//   rr_first_one()       : rotating first-one search used by the round-robin arbiter
package n_way_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on channel count; the search function works on this fixed width and callers
  // zero-extend their request vectors into it.
  localparam int unsigned MaxChannels = 16;
  localparam int unsigned MaxSelW     = 4;

  typedef struct packed {
    logic               found;
    logic [MaxSelW-1:0] idx;
  } rr_pick_t;

  // Return the first set bit of req[n-1:0], scanning from ptr+1 upward and wrapping modulo n.
  // ptr itself is checked last, so the previous winner has lowest priority.
  function automatic rr_pick_t rr_first_one(input logic [MaxChannels-1:0] req,
                                            input logic [MaxSelW-1:0]     ptr,
                                            input int unsigned            n);
    rr_pick_t           pick;
    logic [MaxSelW-1:0] k;
    pick = '0;
    for (int unsigned off = 1; off <= MaxChannels; off++) begin
      k = MaxSelW'((32'(ptr) + off) % n);
      if (off <= n && !pick.found && req[k]) begin
        pick.found = 1'b1;
        pick.idx   = k;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i       : per-channel request vector
//   ptr_i       : index of the last channel granted (lowest priority this round)
//   gnt_idx_o   : winning channel index, valid only when gnt_valid_o is set
//   gnt_valid_o : at least one request present
module rr_arbiter
  import n_way_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [SEL_W-1:0]    gnt_idx_o,
  output logic                gnt_valid_o
);

  rr_pick_t pick;

  always_comb begin
    pick        = rr_first_one(MaxChannels'(req_i), MaxSelW'(ptr_i), CHANNELS);
    gnt_valid_o = pick.found;
    gnt_idx_o   = SEL_W'(pick.idx);
  end

endmodule

// File: rtl/n_way_mux_arb.sv
// N-channel, WIDTH-bit streaming multiplexer with a registered valid/ready output stage.
// Channel selection is either fixed (sel_i) or round-robin, chosen per cycle by mode_i.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   mode_i            : 0 = fixed select, 1 = round-robin
//   sel_i             : channel index used in fixed mode
//   in_valid_i        : per-channel valid
//   in_data_i         : channel k at bits [k*WIDTH +: WIDTH]
//   in_ready_o        : per-channel ready, combinational, only the granted channel can be ready
//   out_valid_o       : output register holds a word
//   out_data_o        : registered data
//   out_chan_o        : channel that supplied out_data_o
//   out_ready_i       : consumer accepts out_data_o
module n_way_mux_arb
  import n_way_mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [CHANNELS-1:0]       in_valid_i,
  input  logic [CHANNELS*WIDTH-1:0] in_data_i,
  output logic [CHANNELS-1:0]       in_ready_o,
  output logic                      out_valid_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic [SEL_W-1:0]          out_chan_o,
  input  logic                      out_ready_i
);

  if (CHANNELS < 2 || CHANNELS > MaxChannels) begin : g_bad_channels
    $error("n_way_mux_arb: CHANNELS must be in 2..16");
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             can_load;
  logic             fix_valid;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .req_i       (in_valid_i),
    .ptr_i       (ptr_q),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  // Pass-through stage: a held word that is being drained frees the register this cycle.
  assign can_load = !out_valid_q || out_ready_i;

  // An out-of-range sel_i (non-power-of-two CHANNELS) simply never grants.
  assign fix_valid = (32'(sel_i) < CHANNELS) && in_valid_i[sel_i];

  always_comb begin
    if (mode_i == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      gnt_valid = fix_valid;
      gnt_idx   = sel_i;
    end
  end

  assign xfer = gnt_valid && in_valid_i[gnt_idx] && can_load;

  // Gated by rst_ni: during reset out_valid_q is 0, which would otherwise make can_load high.
  always_comb begin
    in_ready_o = '0;
    if (gnt_valid && can_load && rst_ni) begin
      in_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data_i[32'(gnt_idx)*WIDTH +: WIDTH];
      out_chan_d  = gnt_idx;
      if (mode_i == MODE_RR) begin
        ptr_d = gnt_idx;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to the last channel so channel 0 wins the first round-robin grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;

endmodule

// File: tb/tb_n_way_mux_arb.sv
module tb_n_way_mux_arb;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [1:0]   sel;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_chan;
  logic         out_ready;

  int n_checks = 0;
  int n_errors = 0;

  n_way_mux_arb #(
    .WIDTH    (W),
    .CHANNELS (N)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mode_i      (mode),
    .sel_i       (sel),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_chan_o  (out_chan),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = 32'h0;
    out_ready = 1'b1;

    // Reset state, with requests pending: nothing may be ready.
    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_data", 32'(out_data), 32'h0);
    check_eq("rst_out_chan", 32'(out_chan), 32'h0);

    in_valid = 4'b0000;
    rst_n    = 1'b1;
    tick();

    // Fixed mode, sel=2, ch2 carries 0xA5.
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = 32'h00A5_0000;
    settle();
    check_eq("fix_in_ready", 32'(in_ready), 32'h4);
    tick();
    check_eq("fix_out_valid", 32'(out_valid), 32'h1);
    check_eq("fix_out_data", 32'(out_data), 32'hA5);
    check_eq("fix_out_chan", 32'(out_chan), 32'h2);

    // Fixed mode, selected channel idle: drain, hold data and channel.
    sel      = 2'd1;
    in_valid = 4'b1101;
    settle();
    check_eq("idle_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_eq("idle_out_valid", 32'(out_valid), 32'h0);
    check_eq("idle_out_data", 32'(out_data), 32'hA5);
    check_eq("idle_out_chan", 32'(out_chan), 32'h2);

    // Round-robin, all valid: ptr untouched by fixed mode so channel 0 goes first.
    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = 32'h1312_1110;
    for (int i = 0; i < 8; i++) begin
      settle();
      check_eq($sformatf("rr_in_ready_%0d", i), 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      check_eq($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'h1);
      check_eq($sformatf("rr_chan_%0d", i), 32'(out_chan), 32'(i % 4));
      check_eq($sformatf("rr_data_%0d", i), 32'(out_data), 32'(8'h10 + i % 4));
    end

    // Sparse requests: get ptr to 1 first, then 1010 alternates 3,1,3,1.
    in_valid = 4'b0010;
    tick();
    check_eq("sparse_setup_chan", 32'(out_chan), 32'h1);
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("sparse_chan_%0d", i), 32'(out_chan), (i % 2 == 0) ? 32'h3 : 32'h1);
    end

    // Backpressure: load 0x3C from ch2 (ptr=1 so ch2 wins), then stall 3 cycles.
    in_data  = 32'h133C_1110;
    in_valid = 4'b0100;
    tick();
    check_eq("bp_load_data", 32'(out_data), 32'h3C);
    check_eq("bp_load_chan", 32'(out_chan), 32'h2);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h0);
      tick();
      check_eq($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h1);
      check_eq($sformatf("bp_data_%0d", i), 32'(out_data), 32'h3C);
      check_eq($sformatf("bp_chan_%0d", i), 32'(out_chan), 32'h2);
    end
    // Release: ptr stayed at 2, so ch3 then ch0, back-to-back.
    out_ready = 1'b1;
    settle();
    check_eq("bp_rel_in_ready", 32'(in_ready), 32'h8);
    tick();
    check_eq("bp_rel_chan0", 32'(out_chan), 32'h3);
    check_eq("bp_rel_data0", 32'(out_data), 32'h13);
    tick();
    check_eq("bp_rel_valid1", 32'(out_valid), 32'h1);
    check_eq("bp_rel_chan1", 32'(out_chan), 32'h0);
    check_eq("bp_rel_data1", 32'(out_data), 32'h10);

    // Async reset between edges, mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'h0);
    check_eq("arst_in_ready", 32'(in_ready), 32'h0);
    check_eq("arst_out_data", 32'(out_data), 32'h0);
    tick();
    rst_n = 1'b1;
    settle();
    check_eq("arst_rel_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_eq("arst_rel_chan", 32'(out_chan), 32'h0);
    check_eq("arst_rel_data", 32'(out_data), 32'h10);
    tick();
    check_eq("arst_rel_chan_next", 32'(out_chan), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
